game_controller: RTL and testbench



---
 rtl/game_controller.sv | 142 ++++++++++++++
 tb/tb_game_controller.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/game_controller.sv
`default_nettype none
// ============================================================================
// Module   : game_controller
// Function : Moore control FSM for the sequence-memory game. It conditions the
//            enter key and drives the datapath command strobes. The optional
//            RESULT auto-return is enabled by defining RESULT_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module game_controller #(
  parameter int RESULT_CYCLES = 250_000_000,
  parameter int CNT_W         = 28
) (
  input  logic clock_50,
  input  logic reset_n,
  input  logic enter,
  input  logic end_fpga,
  input  logic end_user,
  input  logic end_time,
  input  logic win,
  input  logic match,
  output logic r1,
  output logic r2,
  output logic e1,
  output logic e2,
  output logic e3,
  output logic e4,
  output logic sel
);

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_SEQ    = 3'd2,
    ST_PLAY   = 3'd3,
    ST_CHECK  = 3'd4,
    ST_NEXT   = 3'd5,
    ST_RESULT = 3'd6
  } state_t;

  state_t r_state;
  state_t w_next;

  logic r_sync1;
  logic r_sync2;
  logic r_sync3;
  logic r_enter_p;
  logic w_timeout;

  // Counter must be able to represent RESULT_CYCLES-1.
  if ((CNT_W < 1) || ((CNT_W < 31) && (RESULT_CYCLES > (1 << CNT_W)))) begin : g_cfg_invalid
    $error("game_controller: CNT_W too narrow for RESULT_CYCLES");
  end

  // Enter path: two-flop synchronizer, edge detect, registered pulse.
  always_ff @(posedge clock_50) begin
    if (!reset_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_sync3   <= 1'b0;
      r_enter_p <= 1'b0;
    end else begin
      r_sync1   <= enter;
      r_sync2   <= r_sync1;
      r_sync3   <= r_sync2;
      r_enter_p <= r_sync2 & ~r_sync3;
    end
  end

`ifdef RESULT_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;

  // Held at zero outside RESULT, so it starts from zero on every entry.
  always_ff @(posedge clock_50) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (r_state == ST_RESULT) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

  assign w_timeout = (r_cnt == CNT_W'(RESULT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clock_50) begin
    if (!reset_n) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    r1     = 1'b0;
    r2     = 1'b0;
    e1     = 1'b0;
    e2     = 1'b0;
    e3     = 1'b0;
    e4     = 1'b0;
    sel    = 1'b0;
    case (r_state)
      ST_INIT: begin
        r1     = 1'b1;
        r2     = 1'b1;
        w_next = ST_SETUP;
      end
      ST_SETUP: begin
        e1 = 1'b1;
        if (r_enter_p) w_next = ST_SEQ;
      end
      ST_SEQ: begin
        e3 = 1'b1;
        if (end_fpga) w_next = ST_PLAY;
      end
      ST_PLAY: begin
        e2 = 1'b1;
        if (end_time)      w_next = ST_RESULT;
        else if (end_user) w_next = ST_CHECK;
      end
      ST_CHECK: begin
        if (match && !win) w_next = ST_NEXT;
        else               w_next = ST_RESULT;
      end
      ST_NEXT: begin
        e4     = 1'b1;
        r2     = 1'b1;
        w_next = ST_SEQ;
      end
      ST_RESULT: begin
        sel = 1'b1;
        if (r_enter_p || w_timeout) w_next = ST_INIT;
      end
      default: w_next = ST_INIT;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_game_controller.sv
`default_nettype none
// Directed self-checking bench for game_controller.
module tb_game_controller;

  logic clk = 1'b0;
  logic reset_n, enter, end_fpga, end_user, end_time, win, match;
  logic r1, r2, e1, e2, e3, e4, sel;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   e4_seen = 0;

  localparam logic [6:0] O_INIT   = 7'b1100000;
  localparam logic [6:0] O_SETUP  = 7'b0010000;
  localparam logic [6:0] O_PLAY   = 7'b0001000;
  localparam logic [6:0] O_SEQ    = 7'b0000100;
  localparam logic [6:0] O_NEXT   = 7'b0100010;
  localparam logic [6:0] O_CHECK  = 7'b0000000;
  localparam logic [6:0] O_RESULT = 7'b0000001;

  wire [6:0] outs = {r1, r2, e1, e2, e3, e4, sel};

  game_controller #(.RESULT_CYCLES(10), .CNT_W(4)) dut (
    .clock_50(clk), .reset_n(reset_n), .enter(enter),
    .end_fpga(end_fpga), .end_user(end_user), .end_time(end_time),
    .win(win), .match(match),
    .r1(r1), .r2(r2), .e1(e1), .e2(e2), .e3(e3), .e4(e4), .sel(sel)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
    if (e4 === 1'b1) e4_seen++;
  endtask

  task automatic press_enter;
    enter = 1'b1;
    repeat (4) tick;
    enter = 1'b0;
  endtask

  // From SETUP to PLAY.
  task automatic go_play;
    press_enter;
    end_fpga = 1'b1;
    tick;
    end_fpga = 1'b0;
  endtask

  // From RESULT back to SETUP.
  task automatic to_setup;
    press_enter;
    tick;
    tick;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; enter = 0; end_fpga = 0; end_user = 0;
    end_time = 0; win = 0; match = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_cmp++;
      if (outs !== O_INIT) begin n_bad++; $display("FAIL reset_hold[%0d]: got %b expected %b", i, outs, O_INIT); end
    end
    reset_n = 1'b1;
    n_cmp++;
    if (outs !== O_INIT) begin n_bad++; $display("FAIL reset_release: got %b expected %b", outs, O_INIT); end
    tick;
    n_cmp++;
    if (outs !== O_SETUP) begin n_bad++; $display("FAIL reset_to_setup: got %b expected %b", outs, O_SETUP); end
  endtask

  task automatic test_enter_edge;
    end_fpga = 1'b0;
    enter = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick;
      n_cmp++;
      if (outs !== O_SETUP) begin n_bad++; $display("FAIL enter_wait[%0d]: got %b expected %b", i, outs, O_SETUP); end
    end
    tick;
    n_cmp++;
    if (outs !== O_SEQ) begin n_bad++; $display("FAIL enter_edge4: got %b expected %b", outs, O_SEQ); end
    repeat (16) tick;
    n_cmp++;
    if (outs !== O_SEQ) begin n_bad++; $display("FAIL enter_hold: got %b expected %b", outs, O_SEQ); end
    enter = 1'b0;
    tick;
  endtask

  task automatic test_win_loop;
    e4_seen = 0;
    for (int r = 0; r < 3; r++) begin
      end_fpga = 1'b1;
      tick;
      end_fpga = 1'b0;
      n_cmp++;
      if (outs !== O_PLAY) begin n_bad++; $display("FAIL loop_play[%0d]: got %b expected %b", r, outs, O_PLAY); end
      match = 1'b1;
      win = (r == 2);
      end_user = 1'b1;
      tick;
      end_user = 1'b0;
      n_cmp++;
      if (outs !== O_CHECK) begin n_bad++; $display("FAIL loop_check[%0d]: got %b expected %b", r, outs, O_CHECK); end
      tick;
      if (r < 2) begin
        n_cmp++;
        if (outs !== O_NEXT) begin n_bad++; $display("FAIL loop_next[%0d]: got %b expected %b", r, outs, O_NEXT); end
        tick;
        n_cmp++;
        if (outs !== O_SEQ) begin n_bad++; $display("FAIL loop_seq[%0d]: got %b expected %b", r, outs, O_SEQ); end
      end else begin
        n_cmp++;
        if (outs !== O_RESULT) begin n_bad++; $display("FAIL loop_result: got %b expected %b", outs, O_RESULT); end
      end
    end
    win = 1'b0;
    n_cmp++;
    if (e4_seen !== 2) begin n_bad++; $display("FAIL loop_e4_count: got %0d expected 2", e4_seen); end
  endtask

  task automatic test_mismatch;
    to_setup;
    go_play;
    e4_seen = 0;
    match = 1'b0;
    end_user = 1'b1;
    tick;
    end_user = 1'b0;
    n_cmp++;
    if (outs !== O_CHECK) begin n_bad++; $display("FAIL mismatch_check: got %b expected %b", outs, O_CHECK); end
    tick;
    n_cmp++;
    if (outs !== O_RESULT) begin n_bad++; $display("FAIL mismatch_result: got %b expected %b", outs, O_RESULT); end
    n_cmp++;
    if (e4_seen !== 0) begin n_bad++; $display("FAIL mismatch_e4: got %0d expected 0", e4_seen); end
  endtask

  task automatic test_priority;
    to_setup;
    go_play;
    end_time = 1'b1;
    end_user = 1'b1;
    match = 1'b1;
    tick;
    end_time = 1'b0;
    end_user = 1'b0;
    n_cmp++;
    if (outs !== O_RESULT) begin n_bad++; $display("FAIL priority_result: got %b expected %b", outs, O_RESULT); end
    tick;
    n_cmp++;
    if (outs !== O_RESULT) begin n_bad++; $display("FAIL priority_stay: got %b expected %b", outs, O_RESULT); end
  endtask

  task automatic test_reset_mid_play;
    to_setup;
    go_play;
    n_cmp++;
    if (outs !== O_PLAY) begin n_bad++; $display("FAIL midplay_play: got %b expected %b", outs, O_PLAY); end
    reset_n = 1'b0;
    tick;
    n_cmp++;
    if (outs !== O_INIT) begin n_bad++; $display("FAIL midplay_reset: got %b expected %b", outs, O_INIT); end
    reset_n = 1'b1;
    tick;
    n_cmp++;
    if (outs !== O_SETUP) begin n_bad++; $display("FAIL midplay_setup: got %b expected %b", outs, O_SETUP); end
  endtask

  task automatic test_timeout;
    int drops;
    go_play;
    end_time = 1'b1;
    tick;
    end_time = 1'b0;
    n_cmp++;
    if (outs !== O_RESULT) begin n_bad++; $display("FAIL timeout_enter: got %b expected %b", outs, O_RESULT); end
`ifdef RESULT_TIMEOUT_EN
    repeat (9) tick;
    n_cmp++;
    if (outs !== O_RESULT) begin n_bad++; $display("FAIL timeout_cycle10: got %b expected %b", outs, O_RESULT); end
    tick;
    n_cmp++;
    if (outs !== O_INIT) begin n_bad++; $display("FAIL timeout_init: got %b expected %b", outs, O_INIT); end
`else
    drops = 0;
    repeat (1000) begin
      tick;
      if (outs !== O_RESULT) drops++;
    end
    n_cmp++;
    if (drops !== 0) begin n_bad++; $display("FAIL timeout_hold: got %0d non-RESULT cycles expected 0", drops); end
`endif
  endtask

  initial begin
    test_reset;
    test_enter_edge;
    test_win_loop;
    test_mismatch;
    test_priority;
    test_reset_mid_play;
    test_timeout;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
